// File: rtl/fanout_pkg.sv
// Shared types and defaults for the broadcast fanout scheduler and the tree wrapper.
// Latency: n/a (types only).
// Backpressure: n/a.
// Contents: tree width/latency defaults, arbiter state enum, tag struct.
package fanout_pkg;

  // The fanout tree wrapper is built with these values; keep both sides in step.
  localparam int DATA_W_DEF     = 16;
  localparam int FANOUT_LAT_DEF = 3;

  // Wide enough for the largest supported requester count (8).
  localparam int TAG_ID_W = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_t;

  typedef struct packed {
    logic                v;
    logic [TAG_ID_W-1:0] id;
    logic                last;
  } tag_t;

endpackage

// File: rtl/fanout_bcast_arb_rr_pick.sv
// Rotate-priority encoder: first set request at or above ptr, wrapping upward.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the pick is used.
// Ports: req (request vector), ptr (search start) -> gnt_oh (one-hot), gnt_idx (index), any.
module rr_pick
  import fanout_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [N_REQ-1:0] gnt_oh,
  output logic [ID_W-1:0]  gnt_idx,
  output logic             any
);

  logic            found;
  logic [ID_W-1:0] cand;

  always_comb begin
    gnt_oh  = '0;
    gnt_idx = '0;
    found   = 1'b0;
    cand    = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = ID_W'((int'(ptr) + i) % N_REQ);
      if (!found && req[cand]) begin
        found        = 1'b1;
        gnt_oh[cand] = 1'b1;
        gnt_idx      = cand;
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/fanout_bcast_arb.sv
// Round-robin scheduler feeding one scalar per cycle into the broadcast fanout tree, with tags.
// Latency: req_v -> grant 1 cycle, accept -> fo_data_v 1 cycle, fo_data_v -> tag_v FANOUT_LAT cycles.
// Backpressure: req_rdy of the granted source mirrors dst_rdy; the tree itself never stalls.
// Ports: clk/rst; req_v/req_data/req_last/req_rdy per requester; dst_rdy from the PE array;
//        fo_data_v/fo_in_data to the tree; tag_v/tag_id/tag_last aligned to tree output; busy.
module fanout_bcast_arb
  import fanout_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int FANOUT_LAT = FANOUT_LAT_DEF,
  parameter int MAX_BURST  = 8,
  localparam int ID_W      = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_v,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  input  logic [N_REQ-1:0]        req_last,
  output logic [N_REQ-1:0]        req_rdy,
  input  logic                    dst_rdy,
  output logic                    fo_data_v,
  output logic [DATA_W-1:0]       fo_in_data,
  output logic                    tag_v,
  output logic [ID_W-1:0]         tag_id,
  output logic                    tag_last,
  output logic                    busy
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);

  arb_state_t        state, state_nxt;
  logic [ID_W-1:0]   gnt_id, rr_ptr, pick_idx;
  logic [N_REQ-1:0]  gnt_oh, pick_oh;
  logic              pick_any;
  logic [CNT_W-1:0]  beat_cnt;
  logic [DATA_W-1:0] fo_dat_r, cur_dat;
  tag_t              fo_tag;
  tag_t              tag_pipe [FANOUT_LAT];
  logic              cur_v, cur_last, accept, burst_end, release_gnt, pipe_busy;

  rr_pick #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_rr_pick (
    .req     (req_v),
    .ptr     (rr_ptr),
    .gnt_oh  (pick_oh),
    .gnt_idx (pick_idx),
    .any     (pick_any)
  );

  // Granted source selected through the registered one-hot grant.
  always_comb begin
    cur_dat = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt_oh[i]) cur_dat = req_data[i*DATA_W +: DATA_W];
    end
  end

  assign cur_v    = |(req_v & gnt_oh);
  assign cur_last = |(req_last & gnt_oh);

  // Ready depends only on state, grant and dst_rdy so sources may wait on it.
  assign req_rdy = gnt_oh & {N_REQ{(state == BURST) && dst_rdy}};

  assign accept      = (state == BURST) && cur_v && dst_rdy;
  assign burst_end   = (beat_cnt == CNT_W'(MAX_BURST - 1));
  // A last that coincides with the burst limit is one release, not two.
  assign release_gnt = accept && (cur_last || burst_end);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pick_any) state_nxt = BURST;
      BURST:   if (release_gnt) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      gnt_id   <= '0;
      gnt_oh   <= '0;
      beat_cnt <= '0;
      fo_tag   <= '0;
      fo_dat_r <= '0;
      for (int k = 0; k < FANOUT_LAT; k++) tag_pipe[k] <= '0;
    end else begin
      state <= state_nxt;

      if (state == IDLE && pick_any) begin
        gnt_id   <= pick_idx;
        gnt_oh   <= pick_oh;
        beat_cnt <= '0;
      end

      if (accept) begin
        fo_dat_r <= cur_dat;
        fo_tag   <= '{v: 1'b1, id: TAG_ID_W'(gnt_id), last: cur_last};
        beat_cnt <= beat_cnt + 1'b1;
      end else begin
        fo_tag <= '0;
      end

      if (release_gnt) begin
        rr_ptr   <= (gnt_id == ID_W'(N_REQ - 1)) ? '0 : gnt_id + 1'b1;
        beat_cnt <= '0;
      end

      // Tag travels alongside the tree: enters with fo_data_v, exits with tree output.
      tag_pipe[0] <= fo_tag;
      for (int k = 1; k < FANOUT_LAT; k++) tag_pipe[k] <= tag_pipe[k-1];
    end
  end

  always_comb begin
    pipe_busy = 1'b0;
    for (int k = 0; k < FANOUT_LAT; k++) pipe_busy = pipe_busy | tag_pipe[k].v;
  end

  assign fo_data_v  = fo_tag.v;
  assign fo_in_data = fo_dat_r;
  assign tag_v      = tag_pipe[FANOUT_LAT-1].v;
  assign tag_id     = tag_pipe[FANOUT_LAT-1].id[ID_W-1:0];
  assign tag_last   = tag_pipe[FANOUT_LAT-1].last;
  assign busy       = (state == BURST) | fo_tag.v | pipe_busy;

endmodule

// File: tb/tb_fanout_bcast_arb.sv
module tb_fanout_bcast_arb;
  localparam int N   = 4;
  localparam int W   = 16;
  localparam int LAT = 3;
  localparam int MB  = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_v, req_last, req_rdy;
  logic [N*W-1:0] req_data;
  logic           dst_rdy;
  logic           fo_data_v, tag_v, tag_last, busy;
  logic [W-1:0]   fo_in_data;
  logic [1:0]     tag_id;

  fanout_bcast_arb #(.N_REQ(N), .DATA_W(W), .FANOUT_LAT(LAT), .MAX_BURST(MB)) dut (
    .clk(clk), .rst(rst), .req_v(req_v), .req_data(req_data), .req_last(req_last),
    .req_rdy(req_rdy), .dst_rdy(dst_rdy), .fo_data_v(fo_data_v), .fo_in_data(fo_in_data),
    .tag_v(tag_v), .tag_id(tag_id), .tag_last(tag_last), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Per-requester pending beats (source-side BFM).
  logic [W-1:0] qd [N][$];
  bit           ql [N][$];

  // Reference model: owner of the tree (-1 = nobody), beats in current grant, search start.
  int           m_owner, m_cnt, m_ptr;
  bit           m_fo_v, m_fo_last;
  int           m_fo_id;
  logic [W-1:0] m_fo_d;
  bit           dl_v [LAT];
  int           dl_id [LAT];
  bit           dl_last [LAT];

  int obs_ids[$], obs_last[$], obs_dat[$];
  int e_ids[$], e_last[$], e_dat[$];

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = -1; m_cnt = 0; m_ptr = 0;
    m_fo_v = 0; m_fo_last = 0; m_fo_id = 0; m_fo_d = '0;
    for (int k = 0; k < LAT; k++) begin dl_v[k] = 0; dl_id[k] = 0; dl_last[k] = 0; end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_v[i]          = (qd[i].size() > 0);
      req_data[i*W +: W] = (qd[i].size() > 0) ? qd[i][0] : '0;
      req_last[i]       = (ql[i].size() > 0) ? ql[i][0] : 1'b0;
    end
  endtask

  // What the next rising edge should do, stated as transactions.
  task automatic model_step();
    int o;
    if (rst) begin model_reset(); return; end
    for (int k = LAT-1; k > 0; k--) begin
      dl_v[k] = dl_v[k-1]; dl_id[k] = dl_id[k-1]; dl_last[k] = dl_last[k-1];
    end
    dl_v[0] = m_fo_v; dl_id[0] = m_fo_id; dl_last[0] = m_fo_last;
    o = m_owner;
    if (o >= 0 && qd[o].size() > 0 && dst_rdy) begin
      m_fo_d    = qd[o].pop_front();
      m_fo_last = ql[o].pop_front();
      m_fo_v    = 1;
      m_fo_id   = o;
      if (m_fo_last || m_cnt == MB-1) begin
        m_owner = -1; m_ptr = (o + 1) % N; m_cnt = 0;
      end else begin
        m_cnt++;
      end
    end else begin
      m_fo_v = 0; m_fo_id = 0; m_fo_last = 0;
    end
    if (o < 0) begin
      for (int i = 0; i < N; i++) begin
        if (qd[(m_ptr + i) % N].size() > 0) begin
          m_owner = (m_ptr + i) % N; m_cnt = 0; break;
        end
      end
    end
  endtask

  task automatic check_outs();
    bit any_dl;
    any_dl = 0;
    for (int k = 0; k < LAT; k++) any_dl |= dl_v[k];
    chk("fo_data_v", fo_data_v, m_fo_v);
    chk("fo_in_data", fo_in_data, m_fo_d);
    chk("tag_v", tag_v, dl_v[LAT-1]);
    chk("tag_id", tag_id, dl_id[LAT-1]);
    chk("tag_last", tag_last, dl_last[LAT-1]);
    chk("busy", busy, (m_owner >= 0) || m_fo_v || any_dl);
    if (tag_v) begin obs_ids.push_back(int'(tag_id)); obs_last.push_back(int'(tag_last)); end
    if (fo_data_v) obs_dat.push_back(int'(fo_in_data));
  endtask

  task automatic tick();
    drive();
    #1;
    chk("req_rdy", req_rdy, (m_owner >= 0 && dst_rdy) ? (32'd1 << m_owner) : 32'd0);
    model_step();
    @(posedge clk);
    #1;
    check_outs();
    @(negedge clk);
  endtask

  task automatic run(int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic drain();
    bit idle;
    for (int k = 0; k < 300; k++) begin
      idle = (m_owner < 0);
      for (int i = 0; i < N; i++) if (qd[i].size() > 0) idle = 0;
      if (idle) break;
      tick();
    end
    chk("drain_done", (m_owner < 0), 1);
    run(LAT + 2);
  endtask

  task automatic add_pkt(int id, int len, int base, bit with_last);
    for (int b = 0; b < len; b++) begin
      qd[id].push_back(W'(base + b));
      ql[id].push_back(with_last && (b == len-1));
    end
  endtask

  task automatic clr_obs();
    obs_ids.delete(); obs_last.delete(); obs_dat.delete();
    e_ids.delete(); e_last.delete(); e_dat.delete();
  endtask

  task automatic cmp_q(string tag, int got[$], int exp[$]);
    chk({tag, "_len"}, got.size(), exp.size());
    for (int i = 0; i < got.size() && i < exp.size(); i++) chk(tag, got[i], exp[i]);
  endtask

  task automatic exp_beat(int id, int dat, bit last);
    e_ids.push_back(id); e_dat.push_back(dat); e_last.push_back(int'(last));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int i = 0; i < N; i++) begin qd[i].delete(); ql[i].delete(); end
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; dst_rdy = 1'b0; req_v = '0; req_last = '0; req_data = '0;
    model_reset();
    @(negedge clk);
    do_reset();
    chk("rst_tag_v", tag_v, 0);
    chk("rst_busy", busy, 0);
    chk("rst_fo_v", fo_data_v, 0);
    chk("rst_fo_data", fo_in_data, 0);
    chk("rst_req_rdy", req_rdy, 0);

    // Fairness: every source always has two 2-beat packets queued.
    clr_obs();
    dst_rdy = 1'b1;
    for (int p = 0; p < 2; p++)
      for (int i = 0; i < N; i++) add_pkt(i, 2, 16'h1000*i + 16'h10*p, 1);
    for (int p = 0; p < 2; p++)
      for (int i = 0; i < N; i++) begin
        exp_beat(i, 16'h1000*i + 16'h10*p, 0);
        exp_beat(i, 16'h1000*i + 16'h10*p + 1, 1);
      end
    drain();
    cmp_q("fair_ids", obs_ids, e_ids);
    cmp_q("fair_last", obs_last, e_last);
    cmp_q("fair_dat", obs_dat, e_dat);

    // Single 3-beat packet from requester 2.
    clr_obs();
    qd[2].push_back(16'h0011); ql[2].push_back(0);
    qd[2].push_back(16'h0022); ql[2].push_back(0);
    qd[2].push_back(16'h0033); ql[2].push_back(1);
    exp_beat(2, 16'h0011, 0); exp_beat(2, 16'h0022, 0); exp_beat(2, 16'h0033, 1);
    tick();
    chk("single_no_beat_in_idle", fo_data_v, 0);
    tick();
    chk("single_first_beat_gap", fo_data_v, 1);
    drain();
    cmp_q("single_ids", obs_ids, e_ids);
    cmp_q("single_last", obs_last, e_last);
    cmp_q("single_dat", obs_dat, e_dat);

    // Forced rotation: 12 beats from 1 without an early last, requester 3 waiting.
    clr_obs();
    add_pkt(1, 12, 16'h0100, 1);
    tick();
    add_pkt(3, 2, 16'h0300, 1);
    for (int b = 0; b < 8; b++) exp_beat(1, 16'h0100 + b, 0);
    exp_beat(3, 16'h0300, 0); exp_beat(3, 16'h0301, 1);
    for (int b = 8; b < 12; b++) exp_beat(1, 16'h0100 + b, b == 11);
    drain();
    cmp_q("force_ids", obs_ids, e_ids);
    cmp_q("force_last", obs_last, e_last);
    cmp_q("force_dat", obs_dat, e_dat);

    // Backpressure: dst_rdy toggles while requester 0 streams.
    clr_obs();
    add_pkt(0, 5, 16'h0A00, 1);
    for (int b = 0; b < 5; b++) exp_beat(0, 16'h0A00 + b, b == 4);
    tick(); tick();
    for (int k = 0; k < 6; k++) begin dst_rdy = k[0] ? 1'b0 : 1'b1; tick(); end
    dst_rdy = 1'b1;
    drain();
    cmp_q("bp_ids", obs_ids, e_ids);
    cmp_q("bp_dat", obs_dat, e_dat);

    // Reset after 2 of 5 beats; the pointer must restart at 0.
    add_pkt(2, 5, 16'h0B00, 1);
    tick(); tick(); tick();
    do_reset();
    chk("midrst_tag_v", tag_v, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_fo_v", fo_data_v, 0);
    clr_obs();
    add_pkt(2, 5, 16'h0B00, 1);
    add_pkt(0, 1, 16'h0C00, 1);
    exp_beat(0, 16'h0C00, 1);
    for (int b = 0; b < 5; b++) exp_beat(2, 16'h0B00 + b, b == 4);
    drain();
    cmp_q("midrst_ids", obs_ids, e_ids);
    cmp_q("midrst_dat", obs_dat, e_dat);

    // Last on beat MAX_BURST: a single release, next grant to requester 1.
    clr_obs();
    add_pkt(0, 8, 16'h0D00, 1);
    add_pkt(0, 1, 16'h0D80, 1);
    add_pkt(1, 1, 16'h0E00, 1);
    for (int b = 0; b < 8; b++) exp_beat(0, 16'h0D00 + b, b == 7);
    exp_beat(1, 16'h0E00, 1);
    exp_beat(0, 16'h0D80, 1);
    drain();
    cmp_q("max_ids", obs_ids, e_ids);
    cmp_q("max_last", obs_last, e_last);
    cmp_q("max_dat", obs_dat, e_dat);

    // Random traffic against the model, with one reset in the middle.
    for (int c = 0; c < 600; c++) begin
      dst_rdy = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++)
        if (qd[i].size() == 0 && $urandom_range(0, 4) == 0)
          add_pkt(i, int'($urandom_range(1, 12)), int'($urandom_range(0, 16'hFFF0)), 1);
      if (c == 300) do_reset();
      else tick();
    end
    dst_rdy = 1'b1;
    drain();
    chk("end_busy", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
